// File: rtl/forward_hazard_unit_pkg.sv
// Shared constants for the forwarding / hazard-detection slice.
package forward_hazard_unit_pkg;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Default geometry of the pipeline this unit was built for.
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_N_STG   = 2;
  localparam int DEF_MDU_LAT = 4;

  // MDU busy counter is wide enough for the largest legal latency (15).
  localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// Priority match of one EX source register against all forwarding stages.
// The youngest stage (lowest index) wins; register 0 never forwards.
module fwd_select
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int N_STG  = DEF_N_STG,
  parameter int SEL_W  = $clog2(DEF_N_STG + 1)
) (
  input  logic [N_STG-1:0]             regwrite,
  input  logic [N_STG-1:0][REG_AW-1:0] rd,
  input  logic [REG_AW-1:0]            src,
  output logic [SEL_W-1:0]             sel
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    for (int k = N_STG - 1; k >= 0; k--) begin
      if (regwrite[k] && (rd[k] != '0) && (rd[k] == src))
        sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding selects, load-use / MDU hazard stall, MDU busy tracking and a
// saturating stall-cycle counter.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int N_STG   = DEF_N_STG,
  parameter int MDU_LAT = DEF_MDU_LAT,
  parameter int SEL_W   = $clog2(N_STG + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_STG-1:0]        stg_regwrite,
  input  logic [N_STG*REG_AW-1:0] stg_rd,
  input  logic [REG_AW-1:0]       ex_rs,
  input  logic [REG_AW-1:0]       ex_rt,
  input  logic                    ex_memread,
  input  logic [REG_AW-1:0]       ex_rd,
  input  logic [REG_AW-1:0]       id_rs,
  input  logic [REG_AW-1:0]       id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic                    id_mdu_op,
  input  logic                    id_hilo_rd,
  output logic [SEL_W-1:0]        fwd_a,
  output logic [SEL_W-1:0]        fwd_b,
  output logic                    stall,
  output logic                    idex_flush,
  output logic                    mdu_busy,
  output logic [15:0]             stall_cnt
);

  // Flat stage bus viewed as one destination register per stage.
  logic [N_STG-1:0][REG_AW-1:0] stg_rd_v;
  assign stg_rd_v = stg_rd;

  logic [MDU_CNT_W-1:0] mdu_cnt;
  logic                 load_use;
  logic                 mdu_hz;
  logic                 mdu_accept;

  fwd_select #(.REG_AW(REG_AW), .N_STG(N_STG), .SEL_W(SEL_W)) u_fwd_a (
    .regwrite (stg_regwrite),
    .rd       (stg_rd_v),
    .src      (ex_rs),
    .sel      (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW), .N_STG(N_STG), .SEL_W(SEL_W)) u_fwd_b (
    .regwrite (stg_regwrite),
    .rd       (stg_rd_v),
    .src      (ex_rt),
    .sel      (fwd_b)
  );

  // Hazard detection: a load feeding the next instruction, or HI/LO / new
  // MDU work while the MDU is still computing. Stall and bubble go together.
  always_comb begin
    load_use   = ex_memread && (ex_rd != '0) &&
                 ((id_use_rs && (id_rs == ex_rd)) ||
                  (id_use_rt && (id_rt == ex_rd)));
    mdu_hz     = mdu_busy && (id_hilo_rd || id_mdu_op);
    stall      = load_use || mdu_hz;
    idex_flush = stall;
    mdu_accept = id_mdu_op && !stall;
  end

  // Busy is a pure function of the registered counter, so it is glitch-free
  // and high for exactly MDU_LAT cycles after the accepting edge.
  assign mdu_busy = (mdu_cnt != '0);

  // MDU latency counter: load on acceptance, count down to zero. A queued op
  // is accepted the very cycle the counter hits zero, leaving no gap.
  always_ff @(posedge clk) begin
    if (reset)
      mdu_cnt <= '0;
    else if (mdu_accept)
      mdu_cnt <= MDU_CNT_W'(MDU_LAT);
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - MDU_CNT_W'(1);
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Random + directed bench for forward_hazard_unit with a behavioural model.
module tb_forward_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int N_STG   = 2;
  localparam int MDU_LAT = 4;
  localparam int SEL_W   = $clog2(N_STG + 1);

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_STG-1:0]        stg_regwrite;
  logic [N_STG*REG_AW-1:0] stg_rd;
  logic [REG_AW-1:0]       ex_rs, ex_rt, ex_rd, id_rs, id_rt;
  logic                    ex_memread, id_use_rs, id_use_rt, id_mdu_op, id_hilo_rd;
  logic [SEL_W-1:0]        fwd_a, fwd_b;
  logic                    stall, idex_flush, mdu_busy;
  logic [15:0]             stall_cnt;

  int total = 0;
  int bad   = 0;

  forward_hazard_unit #(.REG_AW(REG_AW), .N_STG(N_STG), .MDU_LAT(MDU_LAT), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .stg_regwrite(stg_regwrite), .stg_rd(stg_rd),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu_op(id_mdu_op), .id_hilo_rd(id_hilo_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .idex_flush(idex_flush), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // MDU state is kept as "edge index of the last accepted op"; busy means
  // fewer than MDU_LAT edges have elapsed since then (inclusive of it).
  int m_edge  = 0;
  int m_acc   = -1000;
  int m_sc    = 0;
  bit m_valid = 0;

  function automatic int m_fwd(input logic [REG_AW-1:0] src);
    logic [REG_AW-1:0] r;
    for (int k = 0; k < N_STG; k++) begin
      r = stg_rd[k*REG_AW +: REG_AW];
      if (stg_regwrite[k] && r != 0 && r == src) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit m_busy();
    return (m_edge - m_acc) >= 0 && (m_edge - m_acc) < MDU_LAT;
  endfunction

  function automatic bit m_stall();
    bit lu;
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    return lu || (m_busy() && (id_hilo_rd || id_mdu_op));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_acc   <= -1000;
      m_sc    <= 0;
    end else begin
      if (id_mdu_op && !m_stall()) m_acc <= m_edge + 1;
      if (m_stall()) m_sc <= (m_sc < 65535) ? m_sc + 1 : 65535;
    end
    m_edge <= m_edge + 1;
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("fwd_a",      32'(fwd_a),      32'(m_fwd(ex_rs)));
      chk("fwd_b",      32'(fwd_b),      32'(m_fwd(ex_rt)));
      chk("stall",      32'(stall),      32'(m_stall()));
      chk("idex_flush", 32'(idex_flush), 32'(m_stall()));
      chk("mdu_busy",   32'(mdu_busy),   32'(m_busy()));
      chk("stall_cnt",  32'(stall_cnt),  32'(m_sc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stg_regwrite = '0; stg_rd = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    ex_memread = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_mdu_op = 0; id_hilo_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_rd = 5'd8; id_rt = 5'd8; id_use_rt = 1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();
    #1;
    chk("rst_busy", 32'(mdu_busy), 32'd0);
    chk("rst_cnt",  32'(stall_cnt), 32'd0);

    // Both stages write r5: youngest wins, then the older one.
    stg_regwrite = 2'b11; stg_rd = {5'd5, 5'd5}; ex_rs = 5'd5;
    #1 chk("fwd_a_s0", 32'(fwd_a), 32'd1);
    stg_regwrite = 2'b10;
    #1 chk("fwd_a_s1", 32'(fwd_a), 32'd2);
    // Register 0 never forwards.
    stg_regwrite = 2'b11; stg_rd = {5'd0, 5'd0}; ex_rt = 5'd0;
    #1 chk("fwd_b_r0", 32'(fwd_b), 32'd0);
    tick();

    // Load-use: one stall cycle, counted once.
    do_reset();
    set_load_use();
    #1 chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_flush", 32'(idex_flush), 32'd1);
    tick();
    idle();
    #1 chk("lu_stall_off", 32'(stall), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);

    // MDU op then mfhi: stalls exactly MDU_LAT cycles.
    do_reset();
    id_mdu_op = 1;
    #1 chk("mdu_acc_nostall", 32'(stall), 32'd0);
    tick();
    id_mdu_op = 0; id_hilo_rd = 1;
    for (int i = 0; i < MDU_LAT; i++) begin
      #1 chk("hilo_stall", 32'(stall), 32'd1);
      tick();
    end
    #1 chk("hilo_release", 32'(stall), 32'd0);
    chk("hilo_busy_off", 32'(mdu_busy), 32'd0);
    chk("hilo_cnt", 32'(stall_cnt), 32'(MDU_LAT));

    // Reset two cycles into an MDU op clears busy immediately.
    do_reset();
    id_mdu_op = 1;
    tick();
    id_mdu_op = 0; id_hilo_rd = 1;
    tick();
    reset = 1'b1;
    #1 chk("rst_mid_stall", 32'(stall), 32'd1);
    tick();
    #1 chk("rst_mid_busy", 32'(mdu_busy), 32'd0);
    chk("rst_mid_stall_off", 32'(stall), 32'd0);
    reset = 1'b0;

    // MDU op blocked by load-use is accepted once the stall clears.
    do_reset();
    set_load_use();
    id_mdu_op = 1;
    #1 chk("blk_stall", 32'(stall), 32'd1);
    tick();
    ex_memread = 0;
    #1 chk("blk_busy0", 32'(mdu_busy), 32'd0);
    chk("blk_nostall", 32'(stall), 32'd0);
    tick();
    id_mdu_op = 0;
    #1 chk("blk_busy1", 32'(mdu_busy), 32'd1);

    // Back-to-back MDU ops: second waits MDU_LAT cycles, no gap.
    do_reset();
    id_mdu_op = 1;
    tick();
    for (int i = 0; i < MDU_LAT; i++) begin
      #1 chk("b2b_stall", 32'(stall), 32'd1);
      tick();
    end
    #1 chk("b2b_accept", 32'(stall), 32'd0);
    tick();
    id_mdu_op = 0;
    #1 chk("b2b_busy", 32'(mdu_busy), 32'd1);

    // Random traffic with small register numbers to provoke matches.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      stg_regwrite = N_STG'($urandom);
      for (int k = 0; k < N_STG; k++)
        stg_rd[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      ex_rs      = REG_AW'($urandom_range(0, 3));
      ex_rt      = REG_AW'($urandom_range(0, 3));
      ex_rd      = REG_AW'($urandom_range(0, 3));
      id_rs      = REG_AW'($urandom_range(0, 3));
      id_rt      = REG_AW'($urandom_range(0, 3));
      ex_memread = ($urandom_range(0, 3) == 0);
      id_use_rs  = $urandom_range(0, 1);
      id_use_rt  = $urandom_range(0, 1);
      id_mdu_op  = ($urandom_range(0, 3) == 0);
      id_hilo_rd = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Long stall saturates the counter and it stays there.
    do_reset();
    set_load_use();
    repeat (70000) tick();
    #1 chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    repeat (3) tick();
    #1 chk("sat_hold", 32'(stall_cnt), 32'hFFFF);

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
